// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller.
// The interrupt state enum, next-PC select codes, status codes and the deferral counter width live here.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PEND = 2'b01,
      HOLD = 2'b10
   } irq_state_e;

   localparam int unsigned CNT_W = 8;

   localparam logic [2:0] SEL_SEQ = 3'b000;
   localparam logic [2:0] SEL_JR  = 3'b001;
   localparam logic [2:0] SEL_J   = 3'b010;
   localparam logic [2:0] SEL_BR  = 3'b100;

   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_EXC  = 2'b01;
   localparam logic [1:0] ST_IRQ  = 2'b10;

   // Deferral counter increments but sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Request/control bundle between the ID/EX hazard logic and the fetch controller.
// master drives the hazard and interrupt requests; slave is the controller.
interface fetch_ctrl_if;

   logic       branch_taken;
   logic       jump;
   logic       jr;
   logic       load_use;
   logic       exception;
   logic       kernel;
   logic       irq;
   logic       PC_IF_ID_Write;
   logic [2:0] select_PC_next;
   logic [1:0] status;
   logic       ID_EX_flush;
   logic       irq_late;

   modport master (
      output branch_taken, jump, jr, load_use, exception, kernel, irq,
      input  PC_IF_ID_Write, select_PC_next, status, ID_EX_flush, irq_late
   );

   modport slave (
      input  branch_taken, jump, jr, load_use, exception, kernel, irq,
      output PC_IF_ID_Write, select_PC_next, status, ID_EX_flush, irq_late
   );

endinterface

// File: rtl/fetch_ctrl_irq_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt line.
// Used by fetch_ctrl only when FETCH_CTRL_IRQ_SYNC_EN is defined.
module fetch_ctrl_irq_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   // Shift the raw level through two flops; both clear on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing: PC/IF-ID write enable, next-PC select, interrupt/exception vectoring.
// Define FETCH_CTRL_IRQ_SYNC_EN to pass irq through a two-flop synchronizer; otherwise irq must be clk-synchronous.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned IRQ_MAX_DEFER = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] MAX_DEFER_C = CNT_W'(IRQ_MAX_DEFER);

   irq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             irq_late_q, irq_late_d;
   logic             irq_s;
   logic             slot_free_s;
   logic             serve_s;
   logic             write_s;
   logic [2:0]       sel_s;
   logic [1:0]       status_s;
   logic             flush_s;

`ifdef FETCH_CTRL_IRQ_SYNC_EN
   fetch_ctrl_irq_sync u_irq_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (bus.irq),
      .q_o    (irq_s)
   );
`else
   assign irq_s = bus.irq;
`endif

   assign slot_free_s = ~bus.kernel & ~bus.branch_taken & ~bus.exception
                      & ~bus.jr & ~bus.jump & ~bus.load_use;

   // Interrupt FSM next state plus the per-cycle priority arbitration.
   always_comb begin
      state_d  = state_q;
      serve_s  = 1'b0;
      write_s  = 1'b1;
      sel_s    = SEL_SEQ;
      status_s = ST_NONE;
      flush_s  = 1'b0;

      case (state_q)
         IDLE: begin
            if (irq_s) begin
               state_d = PEND;
            end else begin
               state_d = IDLE;
            end
         end
         PEND: begin
            if (!irq_s) begin
               state_d = IDLE;
            end else if (slot_free_s) begin
               serve_s = 1'b1;
               state_d = HOLD;
            end else begin
               state_d = PEND;
            end
         end
         HOLD: begin
            if (!irq_s) begin
               state_d = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A taken branch squashes everything behind it, including a same-cycle exception.
      if (bus.branch_taken) begin
         sel_s   = SEL_BR;
         flush_s = 1'b1;
      end else if (bus.exception) begin
         status_s = ST_EXC;
         flush_s  = 1'b1;
      end else if (serve_s) begin
         status_s = ST_IRQ;
         flush_s  = 1'b1;
      end else if (bus.jr) begin
         sel_s = SEL_JR;
      end else if (bus.jump) begin
         sel_s = SEL_J;
      end else if (bus.load_use) begin
         write_s = 1'b0;
         flush_s = 1'b1;
      end else begin
         write_s = 1'b1;
      end
   end

   // Counter runs only while the request stays parked in PEND; irq_late lags the counter by one edge.
   always_comb begin
      cnt_d      = {CNT_W{1'b0}};
      irq_late_d = 1'b0;
      if ((state_q == PEND) && (state_d == PEND)) begin
         cnt_d      = sat_inc(cnt_q);
         irq_late_d = (cnt_q >= MAX_DEFER_C);
      end else begin
         cnt_d      = {CNT_W{1'b0}};
         irq_late_d = 1'b0;
      end
   end

   // State, deferral counter and late flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         irq_late_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         irq_late_q <= irq_late_d;
      end
   end

   // During reset the fetch stage free-runs sequentially regardless of the request inputs.
   assign bus.PC_IF_ID_Write = rst_n ? write_s  : 1'b1;
   assign bus.select_PC_next = rst_n ? sel_s    : SEL_SEQ;
   assign bus.status         = rst_n ? status_s : ST_NONE;
   assign bus.ID_EX_flush    = rst_n ? flush_s  : 1'b0;
   assign bus.irq_late       = irq_late_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: priority arbitration, load-use stall, interrupt service,
// deferral watchdog, exception interplay and reset behaviour.
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_IRQ_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   // {write, select[2:0], status[1:0], flush}
   localparam logic [6:0] O_IDLE = 7'b1_000_00_0;
   localparam logic [6:0] O_BR   = 7'b1_100_00_1;
   localparam logic [6:0] O_EXC  = 7'b1_000_01_1;
   localparam logic [6:0] O_IRQ  = 7'b1_000_10_1;
   localparam logic [6:0] O_JR   = 7'b1_001_00_0;
   localparam logic [6:0] O_J    = 7'b1_010_00_0;
   localparam logic [6:0] O_LU   = 7'b0_000_00_1;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   fetch_ctrl_if bus ();

   fetch_ctrl #(.IRQ_MAX_DEFER(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [6:0] outs_s;
   assign outs_s = {bus.PC_IF_ID_Write, bus.select_PC_next, bus.status, bus.ID_EX_flush};

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [6:0] exp, input logic late_exp);
      #1;
      check_eq(tag, {1'b0, outs_s}, {1'b0, exp});
      check_eq({tag, "_late"}, {7'b0, bus.irq_late}, {7'b0, late_exp});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.branch_taken = 1'b0;
      bus.jump         = 1'b0;
      bus.jr           = 1'b0;
      bus.load_use     = 1'b0;
      bus.exception    = 1'b0;
      bus.kernel       = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clk    = 1'b0;
      rst_n  = 1'b0;
      bus.irq = 1'b0;
      clr();
      bus.branch_taken = 1'b1;
      bus.load_use     = 1'b1;
      chk_outs("rst_forced", O_IDLE, 1'b0);
      clr();
      cyc(2);
      rst_n = 1'b1;
      cyc(1);

      for (int i = 0; i < 4; i++) begin
         chk_outs("idle", O_IDLE, 1'b0);
         cyc(1);
      end

      bus.branch_taken = 1'b1; bus.jump = 1'b1; bus.exception = 1'b1;
      chk_outs("br_over_exc_j", O_BR, 1'b0);
      clr(); bus.branch_taken = 1'b1; bus.load_use = 1'b1; bus.jr = 1'b1;
      chk_outs("br_over_lu_jr", O_BR, 1'b0);
      clr(); bus.exception = 1'b1; bus.jr = 1'b1; bus.kernel = 1'b1;
      chk_outs("exc_over_jr", O_EXC, 1'b0);
      clr(); bus.jr = 1'b1;
      chk_outs("jr", O_JR, 1'b0);
      bus.jump = 1'b1;
      chk_outs("jr_over_j", O_JR, 1'b0);
      clr(); bus.jump = 1'b1; bus.load_use = 1'b1;
      chk_outs("j_over_lu", O_J, 1'b0);
      clr();
      cyc(1);

      bus.load_use = 1'b1;
      chk_outs("lu_stall", O_LU, 1'b0);
      cyc(1);
      bus.load_use = 1'b0;
      chk_outs("lu_release", O_IDLE, 1'b0);
      cyc(1);

      // single service per assertion, then re-arm
      bus.irq = 1'b1;
      chk_outs("irq_raise", O_IDLE, 1'b0);
      cyc(1 + SYNC_LAT);
      chk_outs("irq_serve", O_IRQ, 1'b0);
      cyc(1);
      for (int i = 0; i < 10; i++) begin
         chk_outs("irq_hold", O_IDLE, 1'b0);
         cyc(1);
      end
      bus.irq = 1'b0;
      cyc(1 + SYNC_LAT);
      chk_outs("irq_dropped", O_IDLE, 1'b0);
      bus.irq = 1'b1;
      cyc(1 + SYNC_LAT);
      chk_outs("irq_reserve", O_IRQ, 1'b0);
      cyc(1);
      chk_outs("irq_rehold", O_IDLE, 1'b0);
      bus.irq = 1'b0;
      cyc(1 + SYNC_LAT);

      // deferral watchdog; pending entered at edge E1
      bus.kernel = 1'b1;
      bus.irq    = 1'b1;
      cyc(1 + SYNC_LAT);
      chk_outs("pend_kernel", O_IDLE, 1'b0);
      cyc(15);
      chk_outs("late_e16", O_IDLE, 1'b0);
      cyc(1);
      chk_outs("late_e17", O_IDLE, 1'b1);
      for (int i = 0; i < 270; i++) begin
         cyc(1);
         check_eq("late_sat", {7'b0, bus.irq_late}, 8'h01);
      end
      bus.kernel = 1'b0;
      chk_outs("late_serve", O_IRQ, 1'b1);
      cyc(1);
      chk_outs("late_clear", O_IDLE, 1'b0);
      bus.irq = 1'b0;
      cyc(1 + SYNC_LAT);

      // exception while pending keeps the interrupt parked
      bus.kernel = 1'b1;
      bus.irq    = 1'b1;
      cyc(1 + SYNC_LAT);
      bus.kernel    = 1'b0;
      bus.exception = 1'b1;
      chk_outs("pend_exc", O_EXC, 1'b0);
      cyc(1);
      bus.exception = 1'b0;
      bus.kernel    = 1'b1;
      chk_outs("pend_handler", O_IDLE, 1'b0);
      cyc(2);
      bus.kernel = 1'b0;
      chk_outs("pend_after_exc", O_IRQ, 1'b0);
      cyc(1);
      bus.irq = 1'b0;
      cyc(1 + SYNC_LAT);

      // reset mid-PEND with irq withdrawn: nothing served afterwards
      bus.kernel = 1'b1;
      bus.irq    = 1'b1;
      cyc(1 + SYNC_LAT);
      bus.irq      = 1'b0;
      rst_n        = 1'b0;
      bus.kernel   = 1'b0;
      bus.load_use = 1'b1;
      chk_outs("rst_mid_pend", O_IDLE, 1'b0);
      cyc(1);
      rst_n        = 1'b1;
      bus.load_use = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk_outs("post_rst_quiet", O_IDLE, 1'b0);
      end

      // reset mid-HOLD with irq still high: new request after reset
      bus.irq = 1'b1;
      cyc(1 + SYNC_LAT);
      chk_outs("pre_rst_serve", O_IRQ, 1'b0);
      cyc(1);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      chk_outs("rst_release", O_IDLE, 1'b0);
      cyc(1 + SYNC_LAT);
      chk_outs("post_rst_serve", O_IRQ, 1'b0);
      cyc(1);
      chk_outs("post_rst_hold", O_IDLE, 1'b0);
      bus.irq = 1'b0;
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
